// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and parameter defaults.
package uart_pkg;

    // Oversampling ticks per bit period and data bits per frame.
    localparam int OS_DEFAULT   = 16;
    localparam int DBIT_DEFAULT = 8;

    // Legal stop-bit counts; the stop period lasts STOP_BITS*OS ticks.
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Number of s_tick pulses spent in the stop state.
    function automatic int stop_ticks(input int stop_bits, input int os);
        return stop_bits * os;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the host side (master) and the transmit sequencer (slave).
interface uart_tx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEFAULT
) ();

    logic            tx_valid;
    logic [DBIT-1:0] tx_data;
    logic            tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_cfg.sv
// Configuration registers for the transmitter: baud divisor and parity mode.
// Writes are accepted only while the sequencer is idle; a write while busy
// is dropped and flagged with a one-cycle cfg_err pulse.
module uart_baud_cfg #(
    parameter int DIV_W     = 4,
    parameter int DIV_RESET = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_idle,
    input  logic             i_cfg_wr,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_cfg_par_en,
    input  logic             i_cfg_par_odd,
    output logic [DIV_W-1:0] o_baud_div,
    output logic             o_par_en,
    output logic             o_par_odd_eff,
    output logic             o_cfg_err
);

    logic [DIV_W-1:0] r_baud_div;
    logic             r_par_en;
    logic             r_par_odd;
    logic             r_cfg_err;
    logic             w_cfg_ok;

    assign w_cfg_ok = i_cfg_wr & i_idle;

    // Capture accepted config writes; flag writes that arrive mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud_div <= DIV_W'(DIV_RESET);
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, regardless of statement order.
            r_cfg_err <= i_cfg_wr & ~i_idle;
            if (w_cfg_ok) begin
                r_baud_div <= i_cfg_div;
                r_par_en   <= i_cfg_par_en;
                r_par_odd  <= i_cfg_par_odd;
            end
        end
    end

    // A write in the same cycle as a handshake must steer that frame's parity,
    // so the odd/even selection bypasses the register while a write is accepted.
    assign o_par_odd_eff = w_cfg_ok ? i_cfg_par_odd : r_par_odd;
    assign o_par_en      = r_par_en;
    assign o_baud_div    = r_baud_div;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DBIT data bits LSB first, optional
// parity, STOP_BITS stop bits, all timed by the oversampling s_tick.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT      = DBIT_DEFAULT,
    parameter int OS        = OS_DEFAULT,
    parameter int DIV_W     = 4,
    parameter int DIV_RESET = 9,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_ctrl_if.slave      if_tx,
    input  logic               i_cfg_wr,
    input  logic [DIV_W-1:0]   i_cfg_div,
    input  logic               i_cfg_par_en,
    input  logic               i_cfg_par_odd,
    output logic               o_cfg_err,
    output logic [DIV_W-1:0]   o_baud_div,
    input  logic               i_s_tick,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int STOP_TICKS = stop_ticks(STOP_BITS, OS);
    localparam int S_W        = $clog2(STOP_TICKS);
    localparam int N_W        = (DBIT > 1) ? $clog2(DBIT) : 1;

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [S_W-1:0]   r_s_cnt;
    logic [N_W-1:0]   r_n;
    logic [DBIT-1:0]  r_shift;
    logic [DBIT-1:0]  w_shift_next;
    logic             r_par_bit;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_tx_done;

    logic             w_idle;
    logic             w_handshake;
    logic             w_bit_end;
    logic             w_stop_end;
    logic             w_seg_end;
    logic             w_last_bit;
    logic             w_par_en;
    logic             w_par_odd_eff;

    uart_baud_cfg #(
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) u_baud_cfg (
        .clk           (clk),
        .rst           (rst),
        .i_idle        (w_idle),
        .i_cfg_wr      (i_cfg_wr),
        .i_cfg_div     (i_cfg_div),
        .i_cfg_par_en  (i_cfg_par_en),
        .i_cfg_par_odd (i_cfg_par_odd),
        .o_baud_div    (o_baud_div),
        .o_par_en      (w_par_en),
        .o_par_odd_eff (w_par_odd_eff),
        .o_cfg_err     (o_cfg_err)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_handshake = if_tx.tx_valid & w_idle;
    assign w_bit_end   = i_s_tick & (r_s_cnt == S_W'(OS - 1));
    assign w_stop_end  = i_s_tick & (r_s_cnt == S_W'(STOP_TICKS - 1));
    assign w_seg_end   = (r_state == ST_STOP) ? w_stop_end : w_bit_end;
    assign w_last_bit  = (r_n == N_W'(DBIT - 1));

    // State register; async reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: each state ends on the tick that completes its period.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_handshake) w_state_next = ST_START;
            ST_START:  if (w_bit_end)   w_state_next = ST_DATA;
            ST_DATA:   if (w_bit_end && w_last_bit)
                           w_state_next = w_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_bit_end)   w_state_next = ST_STOP;
            ST_STOP:   if (w_stop_end)  w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: next shift value, the line level for the next state, and tx_done.
    always_comb begin
        w_tx_done    = (r_state == ST_STOP) && w_stop_end;
        w_shift_next = r_shift;
        if (w_handshake) begin
            w_shift_next = if_tx.tx_data;
        end else if ((r_state == ST_DATA) && w_bit_end) begin
            w_shift_next = r_shift >> 1;
        end
        // The line is registered, so its value is derived from where the FSM goes next.
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = r_par_bit;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // Datapath: tick counter, bit index, shift register, parity and line register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shift register and counters are reset too; they are few
            // flops and a known value keeps the idle line and debug views clean.
            r_s_cnt   <= '0;
            r_n       <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if (w_handshake) begin
                r_s_cnt   <= '0;
                r_par_bit <= (^if_tx.tx_data) ^ w_par_odd_eff;
            end else if (!w_idle && i_s_tick) begin
                r_s_cnt <= w_seg_end ? '0 : r_s_cnt + 1'b1;
            end
            if ((r_state == ST_START) && w_bit_end) begin
                r_n <= '0;
            end else if ((r_state == ST_DATA) && w_bit_end && !w_last_bit) begin
                r_n <= r_n + 1'b1;
            end
        end
    end

    assign if_tx.tx_ready = w_idle;
    assign o_tx_busy      = ~w_idle;
    assign o_tx           = r_tx;
    assign o_tx_done      = w_tx_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: one instance with one stop bit, one
// with two. A frame is modelled as a list of (level, tick count) segments;
// the expected line level in any cycle follows from how many ticks have
// elapsed since the cycle after the handshake.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_div = 4'd0;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DBIT(8)) bus1 ();
    uart_tx_ctrl_if #(.DBIT(8)) bus2 ();

    assign bus1.tx_valid = valid & ~sel;
    assign bus1.tx_data  = data;
    assign bus2.tx_valid = valid & sel;
    assign bus2.tx_data  = data;

    logic       cfg_wr1, cfg_wr2;
    logic       err1, err2, tx1, tx2, busy1, busy2, done1, done2;
    logic [3:0] baud1, baud2;
    logic [3:0] gen1 = 4'd0, gen2 = 4'd0;
    logic       tick1, tick2;

    assign cfg_wr1 = cfg_wr & ~sel;
    assign cfg_wr2 = cfg_wr & sel;

    // Behavioural baud generators: tick once every (baud_div+1) clocks.
    assign tick1 = (gen1 >= baud1);
    assign tick2 = (gen2 >= baud2);
    always @(posedge clk) begin
        gen1 <= tick1 ? 4'd0 : gen1 + 4'd1;
        gen2 <= tick2 ? 4'd0 : gen2 + 4'd1;
    end

    uart_tx_ctrl #(.DBIT(8), .OS(OS), .DIV_W(4), .DIV_RESET(9), .STOP_BITS(1)) dut1 (
        .clk (clk), .rst (rst), .if_tx (bus1.slave),
        .i_cfg_wr (cfg_wr1), .i_cfg_div (cfg_div), .i_cfg_par_en (par_en), .i_cfg_par_odd (par_odd),
        .o_cfg_err (err1), .o_baud_div (baud1), .i_s_tick (tick1),
        .o_tx (tx1), .o_tx_busy (busy1), .o_tx_done (done1)
    );

    uart_tx_ctrl #(.DBIT(8), .OS(OS), .DIV_W(4), .DIV_RESET(9), .STOP_BITS(2)) dut2 (
        .clk (clk), .rst (rst), .if_tx (bus2.slave),
        .i_cfg_wr (cfg_wr2), .i_cfg_div (cfg_div), .i_cfg_par_en (par_en), .i_cfg_par_odd (par_odd),
        .o_cfg_err (err2), .o_baud_div (baud2), .i_s_tick (tick2),
        .o_tx (tx2), .o_tx_busy (busy2), .o_tx_done (done2)
    );

    logic       m_tx, m_ready, m_busy, m_done, m_err, m_tick;
    logic [3:0] m_baud;
    assign m_tx    = sel ? tx2 : tx1;
    assign m_ready = sel ? bus2.tx_ready : bus1.tx_ready;
    assign m_busy  = sel ? busy2 : busy1;
    assign m_done  = sel ? done2 : done1;
    assign m_err   = sel ? err2 : err1;
    assign m_tick  = sel ? tick2 : tick1;
    assign m_baud  = sel ? baud2 : baud1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_div [2] = '{9, 9};
    bit exp_pe  [2] = '{1'b0, 1'b0};
    bit exp_po  [2] = '{1'b0, 1'b0};
    int last_stop_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", m_tx, 1);
            check("idle_ready", m_ready, 1);
            check("idle_busy", m_busy, 0);
            check("idle_done", m_done, 0);
        end
    endtask

    task automatic do_cfg(input int div, input bit pe, input bit po);
        @(negedge clk);
        cfg_wr  = 1'b1;
        cfg_div = 4'(div);
        par_en  = pe;
        par_odd = po;
        @(negedge clk);
        cfg_wr = 1'b0;
        exp_div[sel] = div;
        exp_pe[sel]  = pe;
        exp_po[sel]  = po;
        check("cfg_baud_div", m_baud, div);
        check("cfg_err_idle", m_err, 0);
    endtask

    // Sends one byte and checks every cycle of the frame against the segment model.
    task automatic send_frame(input logic [7:0] d, input int stop_bits, input bit hold_next,
                              input logic [7:0] next_d, input int poke_at, input int abort_seg,
                              input bit cfg_hs, input bit new_pe, input bit new_po,
                              output int h, output int done_cyc);
        bit lv[$];
        int ln[$];
        int total;
        int ticks;
        int stop_len;
        int wait_cnt;
        bit prev_poke;
        bit exp_done;
        h = -1;
        done_cyc = -1;
        @(negedge clk);
        if (cfg_hs) begin
            cfg_wr  = 1'b1;
            cfg_div = 4'(exp_div[sel]);
            par_en  = new_pe;
            par_odd = new_po;
            exp_pe[sel] = new_pe;
            exp_po[sel] = new_po;
        end
        data  = d;
        valid = 1'b1;
        lv.push_back(1'b0); ln.push_back(OS);
        for (int i = 0; i < 8; i++) begin
            lv.push_back(d[i]); ln.push_back(OS);
        end
        if (exp_pe[sel]) begin
            lv.push_back((^d) ^ exp_po[sel]); ln.push_back(OS);
        end
        lv.push_back(1'b1); ln.push_back(stop_bits * OS);
        total = 0;
        foreach (ln[i]) total += ln[i];

        wait_cnt = 0;
        while (!m_ready) begin
            @(negedge clk);
            wait_cnt++;
            if (wait_cnt > 5000) begin
                check("handshake_timeout", 1, 0);
                valid  = 1'b0;
                cfg_wr = 1'b0;
                return;
            end
        end
        h = cyc;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        if (hold_next) data = next_d;
        else valid = 1'b0;

        ticks = 0;
        stop_len = 0;
        prev_poke = 1'b0;
        for (int k = 1; k <= 20000; k++) begin
            int s;
            int acc;
            @(negedge clk);
            s = 0;
            acc = 0;
            while ((s < lv.size() - 1) && (ticks >= acc + ln[s])) begin
                acc += ln[s];
                s++;
            end
            if ((abort_seg >= 0) && (s == abort_seg)) begin
                rst = 1'b0;
                #1;
                check("abort_tx", m_tx, 1);
                check("abort_ready", m_ready, 1);
                check("abort_done", m_done, 0);
                exp_div = '{9, 9};
                exp_pe  = '{1'b0, 1'b0};
                exp_po  = '{1'b0, 1'b0};
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            exp_done = (ticks == total - 1) && m_tick;
            check("tx", m_tx, lv[s]);
            check("busy_ready", m_ready, 0);
            check("busy_busy", m_busy, 1);
            check("tx_done", m_done, exp_done);
            check("cfg_err", m_err, prev_poke);
            if (s == lv.size() - 1) stop_len++;
            prev_poke = 1'b0;
            cfg_wr = 1'b0;
            if (k == poke_at) begin
                cfg_wr    = 1'b1;
                cfg_div   = 4'd3;
                prev_poke = 1'b1;
            end
            if (!hold_next) begin
                data    = 8'($urandom);
                par_en  = 1'($urandom);
                par_odd = 1'($urandom);
            end
            if (exp_done) begin
                done_cyc = cyc;
                break;
            end
            if (m_tick) ticks++;
        end
        if (done_cyc < 0) begin
            check("done_timeout", 1, 0);
        end else begin
            last_stop_len = stop_len;
            check("stop_len", stop_len, stop_bits * OS * (exp_div[sel] + 1));
            check("frame_baud_div", m_baud, exp_div[sel]);
            if (exp_div[sel] == 0) check("frame_clk", done_cyc - h, total);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int h1, d1, h2, d2;
        logic [7:0] rd;
        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("rst_tx1", tx1, 1);
        check("rst_ready1", bus1.tx_ready, 1);
        check("rst_baud1", baud1, 9);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_err1", err1, 0);
        check("rst_tx2", tx2, 1);
        check("rst_baud2", baud2, 9);
        rst = 1'b1;
        idle_cycles(2);

        // Basic frame, tick every clock.
        do_cfg(0, 0, 0);
        send_frame(8'hA5, 1, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
        check("t1_frame_len", d1 - h1, 160);
        idle_cycles(3);

        // Parity even then odd on 0x07.
        do_cfg(0, 1, 0);
        send_frame(8'h07, 1, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
        check("t2_even_len", d1 - h1, 176);
        do_cfg(0, 1, 1);
        send_frame(8'h07, 1, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
        check("t2_odd_len", d1 - h1, 176);
        idle_cycles(1);

        // Config write during DATA is rejected.
        do_cfg(0, 0, 0);
        send_frame(8'hC3, 1, 0, 8'h00, 40, -1, 0, 0, 0, h1, d1);
        check("t3_frame_len", d1 - h1, 160);
        check("t3_baud_div", m_baud, 0);
        idle_cycles(2);

        // Config write coincident with handshake steers that frame's parity.
        send_frame(8'h3C, 1, 0, 8'h00, 0, -1, 1, 1, 1, h1, d1);
        idle_cycles(2);

        // Back-to-back frames with tx_valid held high.
        do_cfg(0, 0, 0);
        send_frame(8'h55, 1, 1, 8'h0F, 0, -1, 0, 0, 0, h1, d1);
        send_frame(8'h0F, 1, 0, 8'h00, 0, -1, 0, 0, 0, h2, d2);
        check("t4_gap", h2 - d1, 1);
        idle_cycles(2);

        // Reset during data bit 3, then a clean frame.
        send_frame(8'h96, 1, 0, 8'h00, 0, 4, 0, 0, 0, h1, d1);
        check("t5_baud_reset", m_baud, 9);
        idle_cycles(20);
        do_cfg(0, 0, 0);
        send_frame(8'h96, 1, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
        idle_cycles(1);

        // Randomised frames on the single-stop instance.
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            do_cfg(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
            send_frame(rd, 1, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        // Two stop bits, divisor 2.
        @(negedge clk);
        sel = 1'b1;
        do_cfg(2, 0, 0);
        send_frame(8'hE1, 2, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
        check("t6_stop_clk", last_stop_len, 96);
        idle_cycles(2);
        rd = 8'($urandom);
        do_cfg(1, 1, 0);
        send_frame(rd, 2, 0, 8'h00, 0, -1, 0, 0, 0, h1, d1);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
